// File: rtl/micro_pkg.sv
// Shared types and fixed microstate addresses for the control-unit microsequencer.
// The microstore word pairs a next-state selector with a jump target.
package micro_pkg;

    typedef enum logic [2:0] {
        SEL_INC      = 3'd0,
        SEL_DISPATCH = 3'd1,
        SEL_JUMP     = 3'd2,
        SEL_CJUMP    = 3'd3,
        SEL_WAIT_MFA = 3'd4,
        SEL_RETURN   = 3'd5
    } sel_t;

    typedef struct packed {
        sel_t       sel;
        logic [7:0] target;
    } uword_t;

    localparam logic [7:0] RESET_STATE = 8'h00;
    localparam logic [7:0] FETCH       = 8'h01;
    localparam logic [7:0] TRAP        = 8'h41;
    localparam logic [7:0] ILLEGAL     = 8'h42;
    localparam logic [7:0] BUSERR      = 8'h43;

    function automatic uword_t mk_word(input sel_t s, input logic [7:0] t);
        uword_t w;
        w.sel    = s;
        w.target = t;
        return w;
    endfunction

endpackage

// File: rtl/micro_rom.sv
// Combinational microstore: maps the current microstate to its control word.
// Any address not listed below returns to fetch (or trap) via RETURN.
module micro_rom
    import micro_pkg::*;
(
    input  logic [7:0] addr,
    output uword_t     word
);

    always_comb begin
        word = mk_word(SEL_RETURN, 8'h00);
        case (addr)
            8'h00, 8'h01, 8'h03:   word = mk_word(SEL_INC, 8'h00);
            8'h02:                 word = mk_word(SEL_WAIT_MFA, 8'h00);
            8'h04:                 word = mk_word(SEL_DISPATCH, 8'h00);
            8'h09:                 word = mk_word(SEL_CJUMP, 8'h0B);
            TRAP, ILLEGAL, BUSERR: word = mk_word(SEL_JUMP, FETCH);
            default:               ;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microsequencer: registered microstate stepped by the microstore selector, with
// a memory-wait watchdog and fixed illegal-instruction / bus-error diversions.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] enc_state,
    input  logic       mfa,
    input  logic       cond,
    input  logic       trap_req,
    input  logic       hold,
    output logic [7:0] state,
    output logic       dispatched,
    output logic       illegal,
    output logic       bus_err,
    output logic       waiting
);

    // Last low-mfa cycle index before the watchdog fires (count starts at 0).
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    uword_t     word;
    logic [7:0] wd;
    logic [7:0] state_nxt;
    logic [7:0] wd_nxt;
    logic       dispatched_nxt;
    logic       illegal_nxt;
    logic       bus_err_nxt;

    micro_rom u_rom (
        .addr (state),
        .word (word)
    );

    // mfa is a level, not a request/ack pair: memory holds it high once the
    // access is done, and it is only looked at while the selector is WAIT_MFA.
    assign waiting = (word.sel == SEL_WAIT_MFA) && !mfa;

    // The watchdog only survives a cycle that stays in a wait state with mfa
    // low; every other step clears it, so entering a wait always starts at 0.
    always_comb begin
        state_nxt      = state + 8'd1;
        wd_nxt         = 8'd0;
        dispatched_nxt = 1'b0;
        illegal_nxt    = 1'b0;
        bus_err_nxt    = 1'b0;
        case (word.sel)
            SEL_INC: ;
            SEL_DISPATCH: begin
                if (enc_state == 8'h00) begin
                    state_nxt   = ILLEGAL;
                    illegal_nxt = 1'b1;
                end else begin
                    state_nxt      = enc_state;
                    dispatched_nxt = 1'b1;
                end
            end
            SEL_JUMP:  state_nxt = word.target;
            SEL_CJUMP: state_nxt = cond ? word.target : state + 8'd1;
            SEL_WAIT_MFA: begin
                if (mfa) begin
                    state_nxt = state + 8'd1;
                end else if (wd == WD_LAST) begin
                    state_nxt   = BUSERR;
                    bus_err_nxt = 1'b1;
                end else begin
                    state_nxt = state;
                    wd_nxt    = wd + 8'd1;
                end
            end
            SEL_RETURN: state_nxt = trap_req ? TRAP : FETCH;
            default:    state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RESET_STATE;
            wd         <= 8'd0;
            dispatched <= 1'b0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
        end else if (hold) begin
            dispatched <= 1'b0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wd         <= wd_nxt;
            dispatched <= dispatched_nxt;
            illegal    <= illegal_nxt;
            bus_err    <= bus_err_nxt;
        end
    end

endmodule
